// File: rtl/mem_wb_stage.sv
// Memory-access pipeline stage: issues load/store over a req/ack data-memory port,
// stalls upstream while the access is outstanding and registers the MEM/WB bundle.
module mem_wb_stage #(
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              nop_in,
  input  logic [31:0]       alu_result,
  input  logic [31:0]       store_data,
  input  logic [4:0]        rd_in,
  input  logic              we_in,
  input  logic              is_lw,
  input  logic              is_sw,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ack,
  output logic              bus_err,
  output logic              nop,
  output logic [31:0]       value,
  output logic [4:0]        rd,
  output logic              we
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [CNT_W-1:0] r_cnt;
  logic             w_memop;
  logic             w_req;
  logic             w_abort;
  logic             w_stall;
  logic             r_nop;
  logic [31:0]      r_value;
  logic [4:0]       r_rd;
  logic             r_we;

  assign w_memop = ~nop_in & (is_lw | is_sw);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: if (w_memop && !dmem_ack) w_nextState = S_WAIT;
      S_WAIT: if (w_abort || dmem_ack) w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // An ack that coincides with the abort cycle is ignored because the request is already down.
  always_comb begin
    w_req   = 1'b0;
    w_abort = 1'b0;
    case (r_state)
      S_IDLE: w_req = w_memop;
      S_WAIT: begin
        w_req   = (r_cnt < TO_CNT);
        w_abort = (r_cnt == TO_CNT);
      end
      default: begin
        w_req   = 1'b0;
        w_abort = 1'b0;
      end
    endcase
    w_stall = w_req & ~dmem_ack;
  end

  // The first request cycle happens in IDLE, so entering WAIT already counts one unanswered cycle;
  // this keeps dmem_req high for exactly TIMEOUT cycles before the abort.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      r_cnt <= (w_memop && !dmem_ack) ? CNT_W'(1) : '0;
    end else if (w_abort || dmem_ack) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_nop   <= 1'b1;
      r_we    <= 1'b0;
      r_value <= '0;
      r_rd    <= '0;
    end else if (w_stall || w_abort) begin
      r_nop <= 1'b1;
      r_we  <= 1'b0;
    end else begin
      r_nop   <= nop_in;
      r_rd    <= rd_in;
      r_value <= (is_lw && !is_sw && !nop_in) ? dmem_rdata : alu_result;
      r_we    <= we_in & ~nop_in & ~is_sw & (rd_in != 5'd0);
    end
  end

  assign dmem_req   = w_req;
  assign dmem_we    = is_sw;
  assign dmem_addr  = alu_result[ADDR_W-1:0];
  assign dmem_wdata = store_data;
  assign stall      = w_stall;
  assign bus_err    = w_abort;
  assign nop        = r_nop;
  assign value      = r_value;
  assign rd         = r_rd;
  assign we         = r_we;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: directed instructions push expected MEM/WB bundles,
// a monitor pops and compares whenever the stage presents a non-bubble result.
module tb_mem_wb_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        nop_in;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [4:0]  rd_in;
  logic        we_in;
  logic        is_lw;
  logic        is_sw;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [11:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        bus_err;
  logic        nop;
  logic [31:0] value;
  logic [4:0]  rd;
  logic        we;

  typedef struct {
    logic [31:0] value;
    logic [4:0]  rd;
    logic        we;
  } wb_t;

  wb_t expQ[$];
  int  nChecks = 0;
  int  nFails  = 0;

  mem_wb_stage #(.ADDR_W(12), .TIMEOUT(15)) dut (
    .clock(clock), .reset(reset), .nop_in(nop_in), .alu_result(alu_result),
    .store_data(store_data), .rd_in(rd_in), .we_in(we_in), .is_lw(is_lw), .is_sw(is_sw),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .bus_err(bus_err), .nop(nop), .value(value), .rd(rd), .we(we)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic n, input logic lw, input logic sw, input logic [31:0] alu,
                               input logic [31:0] sdata, input logic [4:0] rdi, input logic wei,
                               input logic ack, input logic [31:0] rdata);
    nop_in     = n;
    is_lw      = lw;
    is_sw      = sw;
    alu_result = alu;
    store_data = sdata;
    rd_in      = rdi;
    we_in      = wei;
    dmem_ack   = ack;
    dmem_rdata = rdata;
  endtask

  task automatic idle();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic pushExp(input logic [31:0] v, input logic [4:0] r, input logic w);
    wb_t e;
    e.value = v;
    e.rd    = r;
    e.we    = w;
    expQ.push_back(e);
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  // Monitor: every non-bubble MEM/WB result must match the oldest expected bundle.
  always @(negedge clock) begin
    if (reset === 1'b0 && nop === 1'b0) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_result", {27'd0, rd, value}, 64'h0);
      end else begin
        wb_t e;
        e = expQ.pop_front();
        checkOutput("wb_bundle", {26'd0, we, rd, value}, {26'd0, e.we, e.rd, e.value});
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  reqCycles;
    logic abortSeen;

    reset = 1'b1;
    idle();
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("reset_nop", nop, 1);
    checkOutput("reset_we", we, 0);
    checkOutput("reset_value", value, 0);
    checkOutput("reset_rd", rd, 0);
    checkOutput("reset_req", dmem_req, 0);
    nextCycle();
    reset = 1'b0;

    // ALU op
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h2A, 32'h0, 5'd3, 1'b1, 1'b0, 32'h0);
    pushExp(32'h2A, 5'd3, 1'b1);
    @(negedge clock);
    checkOutput("alu_stall", stall, 0);
    checkOutput("alu_req", dmem_req, 0);
    nextCycle();
    idle();
    @(negedge clock);
    checkOutput("alu_stall_after", stall, 0);
    nextCycle();

    // lw with two wait cycles, ack in the third request cycle
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 5'd5, 1'b1, 1'b0, 32'h0);
    pushExp(32'hDEADBEEF, 5'd5, 1'b1);
    @(negedge clock);
    checkOutput("lw_req", dmem_req, 1);
    checkOutput("lw_dmem_we", dmem_we, 0);
    checkOutput("lw_addr", dmem_addr, 12'h010);
    checkOutput("lw_stall1", stall, 1);
    nextCycle();
    @(negedge clock);
    checkOutput("lw_stall2", stall, 1);
    checkOutput("lw_bubble_nop", nop, 1);
    checkOutput("lw_bubble_we", we, 0);
    nextCycle();
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hDEADBEEF;
    @(negedge clock);
    checkOutput("lw_ack_stall", stall, 0);
    checkOutput("lw_ack_req", dmem_req, 1);
    checkOutput("lw_ack_bubble", nop, 1);
    nextCycle();
    idle();
    @(negedge clock);
    nextCycle();

    // sw with zero-wait ack
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h20, 32'h1234, 5'd7, 1'b1, 1'b1, 32'h0);
    pushExp(32'h20, 5'd7, 1'b0);
    @(negedge clock);
    checkOutput("sw_req", dmem_req, 1);
    checkOutput("sw_dmem_we", dmem_we, 1);
    checkOutput("sw_wdata", dmem_wdata, 32'h1234);
    checkOutput("sw_stall", stall, 0);
    nextCycle();
    idle();
    @(negedge clock);
    nextCycle();

    // lw that never gets an ack
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h30, 32'h0, 5'd6, 1'b1, 1'b0, 32'h0);
    reqCycles = 0;
    abortSeen = 1'b0;
    for (int i = 0; i < 40 && !abortSeen; i++) begin
      @(negedge clock);
      if (bus_err === 1'b1) begin
        abortSeen = 1'b1;
      end else begin
        if (dmem_req === 1'b1) reqCycles++;
        nextCycle();
      end
    end
    checkOutput("timeout_abort_seen", abortSeen, 1);
    checkOutput("timeout_req_cycles", reqCycles, 15);
    checkOutput("timeout_abort_stall", stall, 0);
    checkOutput("timeout_abort_req", dmem_req, 0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h55, 32'h0, 5'd9, 1'b1, 1'b0, 32'h0);
    pushExp(32'h55, 5'd9, 1'b1);
    @(negedge clock);
    checkOutput("timeout_drop_nop", nop, 1);
    checkOutput("timeout_err_pulse", bus_err, 0);
    checkOutput("post_timeout_stall", stall, 0);
    nextCycle();
    idle();
    @(negedge clock);
    nextCycle();

    // Edge cases: write to r0, lw+sw together, bubble carrying is_lw
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h77, 32'h0, 5'd0, 1'b1, 1'b0, 32'h0);
    pushExp(32'h77, 5'd0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h40, 32'hCAFE, 5'd8, 1'b1, 1'b1, 32'h1111);
    pushExp(32'h40, 5'd8, 1'b0);
    @(negedge clock);
    checkOutput("lwsw_dmem_we", dmem_we, 1);
    checkOutput("lwsw_req", dmem_req, 1);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h50, 32'h0, 5'd10, 1'b1, 1'b0, 32'h0);
    @(negedge clock);
    checkOutput("bubble_lw_req", dmem_req, 0);
    checkOutput("bubble_lw_stall", stall, 0);
    nextCycle();
    idle();
    @(negedge clock);
    checkOutput("bubble_lw_nop", nop, 1);
    checkOutput("bubble_lw_we", we, 0);
    nextCycle();

    // Reset during the third wait cycle of a load
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h60, 32'h0, 5'd4, 1'b1, 1'b0, 32'h0);
    @(negedge clock);
    checkOutput("rst_lw_req", dmem_req, 1);
    nextCycle();
    @(negedge clock);
    checkOutput("rst_lw_stall", stall, 1);
    nextCycle();
    reset = 1'b1;
    idle();
    nextCycle();
    reset = 1'b0;
    @(negedge clock);
    checkOutput("rst_wait_req", dmem_req, 0);
    checkOutput("rst_wait_nop", nop, 1);
    checkOutput("rst_wait_we", we, 0);
    checkOutput("rst_wait_value", value, 0);
    checkOutput("rst_wait_rd", rd, 0);
    nextCycle();
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h0BAD;
    @(negedge clock);
    checkOutput("late_ack_req", dmem_req, 0);
    nextCycle();
    idle();
    @(negedge clock);
    checkOutput("late_ack_nop", nop, 1);
    checkOutput("late_ack_we", we, 0);
    nextCycle();

    repeat (2) nextCycle();
    checkOutput("scoreboard_drained", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
